// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared encodings and field limits for the clock design
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } set_state_e;

  localparam int HOUR_W     = 5;
  localparam int MINSEC_W   = 6;
  localparam int HOUR_MAX   = 23;
  localparam int MINSEC_MAX = 59;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo-(MAX+1) counter with carry-out
module mod_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] VAL_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;
  logic             at_max;

  assign at_max = (value_q == VAL_MAX);

  always_comb begin
    value_d = value_q;
    if (en) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = en && at_max;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - timekeeping, time-setting FSM and field blink control
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_TICKS = 25
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                time_flag,
  input  logic                second_tick,
  input  logic                mode_press,
  input  logic                inc_press,
  output logic [HOUR_W-1:0]   hour,
  output logic [MINSEC_W-1:0] minute,
  output logic [MINSEC_W-1:0] second,
  output logic [1:0]          set_sel,
  output logic                blink
);

  localparam int               CNT_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

  set_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  logic inc_acc;
  logic in_run;
  logic sec_en, min_en, hour_en;
  logic sec_carry, min_carry, hour_carry_unused;

  assign in_run  = (state_q == ST_RUN);
  // A mode press on the same edge always wins over an increment.
  assign inc_acc = inc_press && !mode_press && !in_run;

  assign sec_en  = in_run ? second_tick : (inc_acc && state_q == ST_SET_S);
  assign min_en  = in_run ? sec_carry   : (inc_acc && state_q == ST_SET_M);
  assign hour_en = in_run ? min_carry   : (inc_acc && state_q == ST_SET_H);

  mod_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_sec (
    .clock (clock),
    .reset (reset),
    .en    (sec_en),
    .value (second),
    .carry (sec_carry)
  );

  mod_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_min (
    .clock (clock),
    .reset (reset),
    .en    (min_en),
    .value (minute),
    .carry (min_carry)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clock (clock),
    .reset (reset),
    .en    (hour_en),
    .value (hour),
    .carry (hour_carry_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;

    if (mode_press) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
    end

    // Keep the edited digit visible on entry and while it is being adjusted.
    if (in_run || mode_press || inc_acc) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (time_flag) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign set_sel = state_q;
  assign blink   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

  localparam int BLINK = 25;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       time_flag = 1'b0;
  logic       second_tick = 1'b0;
  logic       mode_press = 1'b0;
  logic       inc_press = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] set_sel;
  logic       blink;

  int checks = 0;
  int errors = 0;

  // Behavioural reference model
  int m_h, m_m, m_s, m_st, m_ticks;
  logic m_bl;

  logic [19:0] sb[$];

  clock_set_ctrl #(.BLINK_TICKS(BLINK)) dut (
    .clock       (clock),
    .reset       (reset),
    .time_flag   (time_flag),
    .second_tick (second_tick),
    .mode_press  (mode_press),
    .inc_press   (inc_press),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .set_sel     (set_sel),
    .blink       (blink)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_now(input string tag, input int h, input int mi, input int s,
                           input int sel, input int bl);
    check({tag, ".hour"},    32'(hour),    32'(h));
    check({tag, ".minute"},  32'(minute),  32'(mi));
    check({tag, ".second"},  32'(second),  32'(s));
    check({tag, ".set_sel"}, 32'(set_sel), 32'(sel));
    check({tag, ".blink"},   32'(blink),   32'(bl));
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_ticks = 0; m_bl = 1'b1;
    sb.delete();
  endtask

  task automatic model_step(input logic mo, input logic inc, input logic tk, input logic tf);
    if (m_st == 0) begin
      if (tk) begin
        m_s = m_s + 1;
        if (m_s == 60) begin
          m_s = 0; m_m = m_m + 1;
          if (m_m == 60) begin
            m_m = 0; m_h = (m_h + 1) % 24;
          end
        end
      end
    end else if (inc && !mo) begin
      if (m_st == 1) m_h = (m_h + 1) % 24;
      if (m_st == 2) m_m = (m_m + 1) % 60;
      if (m_st == 3) m_s = (m_s + 1) % 60;
    end
    if (mo) begin
      m_st = (m_st + 1) % 4; m_ticks = 0; m_bl = 1'b1;
    end else if (m_st == 0 || inc) begin
      m_ticks = 0; m_bl = 1'b1;
    end else if (tf) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == BLINK) begin
        m_ticks = 0; m_bl = ~m_bl;
      end
    end
  endtask

  task automatic cycle(input logic mo, input logic inc, input logic tk, input logic tf);
    logic [19:0] exp_v;
    @(negedge clock);
    mode_press = mo; inc_press = inc; second_tick = tk; time_flag = tf;
    @(posedge clock);
    model_step(mo, inc, tk, tf);
    sb.push_back({5'(m_h), 6'(m_m), 6'(m_s), 2'(m_st), m_bl});
    #1;
    mode_press = 1'b0; inc_press = 1'b0; second_tick = 1'b0; time_flag = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_v = sb.pop_front();
      check("cycle", 32'({hour, minute, second, set_sel, blink}), 32'(exp_v));
    end
  endtask

  task automatic repeat_cycle(input int n, input logic mo, input logic inc,
                              input logic tk, input logic tf);
    for (int i = 0; i < n; i++) cycle(mo, inc, tk, tf);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_now("reset_held", 0, 0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b1;

    // Free-running carry from seconds into minutes
    repeat_cycle(61, 0, 0, 1, 0);
    check_now("run_61", 0, 1, 1, 0, 1);

    // inc_press in RUN has no effect
    cycle(0, 1, 0, 0);
    check_now("run_inc_ignored", 0, 1, 1, 0, 1);

    // Preload 23:59:58
    cycle(1, 0, 0, 0);
    repeat_cycle(23, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat_cycle(58, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat_cycle(57, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    check_now("preload", 23, 59, 58, 0, 1);
    repeat_cycle(2, 0, 0, 1, 0);
    check_now("day_wrap", 0, 0, 0, 0, 1);

    // SET_H: 25 increments wrap hour to 1, ticks frozen
    cycle(1, 0, 0, 0);
    repeat_cycle(12, 0, 1, 1, 0);
    repeat_cycle(3, 0, 0, 1, 0);
    repeat_cycle(13, 0, 1, 0, 0);
    check_now("set_h_inc25", 1, 0, 0, 1, 1);

    // Blink toggles after exactly BLINK time_flag ticks, idle cycles interleaved
    for (int i = 0; i < BLINK - 1; i++) begin
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
    end
    check_now("blink_before", 1, 0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    check_now("blink_toggle", 1, 0, 0, 1, 0);
    cycle(0, 1, 0, 1);
    check_now("blink_inc_restore", 2, 0, 0, 1, 1);
    repeat_cycle(BLINK - 1, 0, 0, 0, 1);
    check_now("blink_restart_before", 2, 0, 0, 1, 1);
    cycle(0, 0, 0, 1);
    check_now("blink_restart_toggle", 2, 0, 0, 1, 0);
    repeat_cycle(BLINK, 0, 0, 0, 1);
    check_now("blink_toggle_back", 2, 0, 0, 1, 1);

    // SET_M: mode and inc together, mode wins
    cycle(1, 0, 0, 0);
    repeat_cycle(3, 0, 0, 1, 1);
    cycle(1, 1, 0, 0);
    check_now("mode_inc_same", 2, 0, 0, 3, 1);

    // SET_S with mode+tick: tick dropped, back to RUN
    repeat_cycle(56, 0, 1, 0, 0);
    cycle(1, 0, 1, 0);
    check_now("set_s_mode_tick", 2, 0, 56, 0, 1);

    // RUN with mode+tick: tick applied and SET_H entered
    cycle(1, 0, 1, 0);
    check_now("run_mode_tick", 2, 0, 57, 1, 1);

    // Build 12:34:56, seconds wrap without minute carry
    repeat_cycle(10, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat_cycle(34, 0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    repeat_cycle(59, 0, 1, 0, 0);
    check_now("preset_123456", 12, 34, 56, 3, 1);

    // Asynchronous reset mid-operation
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_now("async_reset", 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    check_now("reset_next_cycle", 0, 0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b1;
    repeat_cycle(3, 0, 0, 1, 1);
    check_now("after_reset_run", 0, 0, 3, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
